// File: rtl/mem_arb_banked.sv
// mem_arb_banked: two-requestor (instruction fetch + load/store) arbiter in
// front of NUM_BANKS word-interleaved single-port memory banks.
//
// Parameters
//   ADDR_W    word-address width of each requestor port
//   DATA_W    word width
//   NUM_BANKS number of interleaved banks (power of two, 1..8)
//
// Ports
//   clk, rst                         clock, asynchronous active-low reset
//   if_req/if_addr                   fetch read request
//   if_gnt                           fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata               fetch response, one cycle after grant
//   ls_req/ls_web/ls_bweb/ls_addr/ls_wdata
//                                    load/store request (web=0 write, bweb
//                                    active-low bit enables)
//   ls_gnt                           load/store accepted this cycle
//   ls_rvalid/ls_rdata               load response, one cycle after grant
//
// Configuration
//   MEM_ARB_RR_EN  defined: same-bank conflicts resolved round-robin.
//                  undefined: load/store always wins a conflict.
module mem_arb_banked #(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_BANKS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_web,
   input  logic [DATA_W-1:0] ls_bweb,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata
);

   localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
   localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
   localparam int unsigned ROWS      = 2 ** ROW_W;

   logic [BANK_W-1:0] if_bank, ls_bank;
   logic [ROW_W-1:0]  if_row, ls_row;
   logic              conflict;
   logic              ls_wins;

   logic [DATA_W-1:0] mem_q [NUM_BANKS][ROWS];

   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

   // Low address bits pick the bank so sequential words alternate banks.
   always_comb begin
      if_row = ROW_W'(if_addr >> BANK_BITS);
      ls_row = ROW_W'(ls_addr >> BANK_BITS);
      if (NUM_BANKS > 1) begin
         if_bank = if_addr[BANK_W-1:0];
         ls_bank = ls_addr[BANK_W-1:0];
      end else begin
         if_bank = '0;
         ls_bank = '0;
      end
   end

   // Reset gates everything so no grant (and hence no write) happens in reset.
   assign conflict = rst & if_req & ls_req & (if_bank == ls_bank);

`ifdef MEM_ARB_RR_EN
   // ls_first_q = 1 means LS has priority on the next conflict.
   logic ls_first_q, ls_first_d;

   assign ls_wins = ls_first_q;

   always_comb begin
      ls_first_d = ls_first_q;
      // The conflict winner drops to lowest priority.
      if (conflict) ls_first_d = ~ls_first_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ls_first_q <= 1'b0;
      else      ls_first_q <= ls_first_d;
   end
`else
   assign ls_wins = 1'b1;
`endif

   assign if_gnt = rst & if_req & ~(conflict & ls_wins);
   assign ls_gnt = rst & ls_req & ~(conflict & ~ls_wins);

   // Arbitration guarantees at most one access per bank per cycle.
   always_ff @(posedge clk) begin
      if (ls_gnt && !ls_web) begin
         mem_q[ls_bank][ls_row] <= (mem_q[ls_bank][ls_row] & ls_bweb) | (ls_wdata & ~ls_bweb);
      end
   end

   always_comb begin
      if_rvalid_d = if_gnt;
      ls_rvalid_d = ls_gnt & ls_web;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if (if_gnt)            if_rdata_d = mem_q[if_bank][if_row];
      if (ls_gnt && ls_web)  ls_rdata_d = mem_q[ls_bank][ls_row];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arb_banked.sv
// Directed bench for mem_arb_banked: a 2-bank instance for the main behaviour
// and a 1-bank instance for the all-requests-conflict case.
module tb_mem_arb_banked;

   logic        clk;
   logic        rst;

   logic        if_req, if_gnt, if_rvalid;
   logic [13:0] if_addr;
   logic [31:0] if_rdata;
   logic        ls_req, ls_web, ls_gnt, ls_rvalid;
   logic [31:0] ls_bweb, ls_wdata, ls_rdata;
   logic [13:0] ls_addr;

   logic        s_if_req, s_if_gnt, s_if_rvalid;
   logic [7:0]  s_if_addr, s_ls_addr;
   logic [31:0] s_if_rdata, s_ls_rdata;
   logic        s_ls_req, s_ls_gnt, s_ls_rvalid;

   int n_checks;
   int n_errors;

   mem_arb_banked #(.ADDR_W(14), .DATA_W(32), .NUM_BANKS(2)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_web(ls_web), .ls_bweb(ls_bweb), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata)
   );

   mem_arb_banked #(.ADDR_W(8), .DATA_W(32), .NUM_BANKS(1)) u_dut_nb1 (
      .clk(clk), .rst(rst),
      .if_req(s_if_req), .if_addr(s_if_addr), .if_gnt(s_if_gnt),
      .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
      .ls_req(s_ls_req), .ls_web(1'b1), .ls_bweb(32'hFFFF_FFFF), .ls_addr(s_ls_addr),
      .ls_wdata(32'h0), .ls_gnt(s_ls_gnt), .ls_rvalid(s_ls_rvalid), .ls_rdata(s_ls_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req   = 1'b0;
      ls_req   = 1'b0;
      ls_web   = 1'b1;
      ls_bweb  = 32'hFFFF_FFFF;
      s_if_req = 1'b0;
      s_ls_req = 1'b0;
   endtask

   task automatic ls_write(input logic [13:0] addr, input logic [31:0] data,
                           input logic [31:0] bweb);
      ls_req   = 1'b1;
      ls_web   = 1'b0;
      ls_addr  = addr;
      ls_wdata = data;
      ls_bweb  = bweb;
      #1;
      check_eq("ls_wr_gnt", 32'(ls_gnt), 32'd1);
      tick();
      check_eq("ls_wr_no_rvalid", 32'(ls_rvalid), 32'd0);
      idle();
   endtask

   logic [2:0]  exp_if036, exp_ls036;
   logic [1:0]  exp_ls039;
   logic [13:0] b2b_addr [3];
   logic [31:0] b2b_data [3];

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      s_if_addr = 8'h0;
      s_ls_addr = 8'h0;
      ls_wdata  = 32'h0;
      idle();
`ifdef MEM_ARB_RR_EN
      exp_if036 = 3'b101;  // cycle order bit0, bit1, bit2: IF, LS, IF
      exp_ls036 = 3'b010;
      exp_ls039 = 2'b10;   // IF first, then LS
`else
      exp_if036 = 3'b000;
      exp_ls036 = 3'b111;
      exp_ls039 = 2'b11;
`endif

      // Reset: outputs clear, requests ignored, store attempt blocked.
      rst      = 1'b0;
      if_req   = 1'b1;
      if_addr  = 14'h0004;
      ls_req   = 1'b1;
      ls_web   = 1'b0;
      ls_addr  = 14'h0004;
      ls_wdata = 32'h0000_0BAD;
      ls_bweb  = 32'h0;
      #3;
      check_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check_eq("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
      check_eq("rst_if_rdata", if_rdata, 32'h0);
      check_eq("rst_ls_rdata", ls_rdata, 32'h0);
      check_eq("rst_if_gnt", 32'(if_gnt), 32'd0);
      check_eq("rst_ls_gnt", 32'(ls_gnt), 32'd0);
      tick();
      tick();
      idle();
      rst = 1'b1;
      tick();
      check_eq("post_rst_if_rvalid", 32'(if_rvalid), 32'd0);

      // Preload.
      ls_write(14'h0004, 32'hA0A0_A0A4, 32'h0);
      ls_write(14'h0005, 32'hB0B0_B0B5, 32'h0);
      ls_write(14'h0010, 32'h1234_5678, 32'h0);
      ls_write(14'h0008, 32'h8888_8888, 32'h0);

      // Different banks: both granted, both respond next cycle.
      if_req  = 1'b1;
      if_addr = 14'h0004;
      ls_req  = 1'b1;
      ls_web  = 1'b1;
      ls_addr = 14'h0005;
      #1;
      check_eq("dual_if_gnt", 32'(if_gnt), 32'd1);
      check_eq("dual_ls_gnt", 32'(ls_gnt), 32'd1);
      tick();
      idle();
      check_eq("dual_if_rvalid", 32'(if_rvalid), 32'd1);
      check_eq("dual_if_rdata", if_rdata, 32'hA0A0_A0A4);
      check_eq("dual_ls_rvalid", 32'(ls_rvalid), 32'd1);
      check_eq("dual_ls_rdata", ls_rdata, 32'hB0B0_B0B5);
      tick();
      check_eq("hold_if_rvalid", 32'(if_rvalid), 32'd0);
      check_eq("hold_if_rdata", if_rdata, 32'hA0A0_A0A4);
      check_eq("hold_ls_rdata", ls_rdata, 32'hB0B0_B0B5);

      // Partial write: only the low half is enabled.
      ls_write(14'h0010, 32'hDEAD_BEEF, 32'hFFFF_0000);
      ls_req  = 1'b1;
      ls_web  = 1'b1;
      ls_addr = 14'h0010;
      tick();
      idle();
      check_eq("bweb_ls_rdata", ls_rdata, 32'h1234_BEEF);

      // Same-bank, same-address conflict held for three cycles.
      for (int i = 0; i < 3; i++) begin
         if_req  = 1'b1;
         if_addr = 14'h0008;
         ls_req  = 1'b1;
         ls_web  = 1'b1;
         ls_addr = 14'h0008;
         #1;
         check_eq("conf_if_gnt", 32'(if_gnt), 32'(exp_if036[i]));
         check_eq("conf_ls_gnt", 32'(ls_gnt), 32'(exp_ls036[i]));
         tick();
         check_eq("conf_if_rvalid", 32'(if_rvalid), 32'(exp_if036[i]));
         check_eq("conf_ls_rvalid", 32'(ls_rvalid), 32'(exp_ls036[i]));
         if (exp_if036[i]) check_eq("conf_if_rdata", if_rdata, 32'h8888_8888);
         if (exp_ls036[i]) check_eq("conf_ls_rdata", ls_rdata, 32'h8888_8888);
      end
      idle();

      // Read right after write to the same address sees new data.
      ls_write(14'h0020, 32'hCAFE_F00D, 32'h0);
      if_req  = 1'b1;
      if_addr = 14'h0020;
      #1;
      check_eq("raw_if_gnt", 32'(if_gnt), 32'd1);
      tick();
      idle();
      check_eq("raw_if_rdata", if_rdata, 32'hCAFE_F00D);

      // Back-to-back fetches with no bubble.
      b2b_addr[0] = 14'h0004; b2b_data[0] = 32'hA0A0_A0A4;
      b2b_addr[1] = 14'h0008; b2b_data[1] = 32'h8888_8888;
      b2b_addr[2] = 14'h0010; b2b_data[2] = 32'h1234_BEEF;
      for (int i = 0; i < 3; i++) begin
         if_req  = 1'b1;
         if_addr = b2b_addr[i];
         #1;
         check_eq("b2b_if_gnt", 32'(if_gnt), 32'd1);
         tick();
         check_eq("b2b_if_rvalid", 32'(if_rvalid), 32'd1);
         check_eq("b2b_if_rdata", if_rdata, b2b_data[i]);
      end
      idle();

      // Reset mid-cycle with a response showing and another read granted.
      if_req  = 1'b1;
      if_addr = 14'h0004;
      tick();
      check_eq("pre_rst_if_rvalid", 32'(if_rvalid), 32'd1);
      if_addr = 14'h0008;
      #2;
      rst = 1'b0;
      #1;
      check_eq("midrst_if_rvalid", 32'(if_rvalid), 32'd0);
      check_eq("midrst_if_rdata", if_rdata, 32'h0);
      check_eq("midrst_if_gnt", 32'(if_gnt), 32'd0);
      ls_req   = 1'b1;
      ls_web   = 1'b0;
      ls_addr  = 14'h0004;
      ls_wdata = 32'h0000_0BAD;
      ls_bweb  = 32'h0;
      tick();
      tick();
      idle();
      rst = 1'b1;
      tick();
      check_eq("rel_if_rvalid", 32'(if_rvalid), 32'd0);
      check_eq("rel_ls_rvalid", 32'(ls_rvalid), 32'd0);
      if_req  = 1'b1;
      if_addr = 14'h0004;
      tick();
      idle();
      check_eq("no_rst_write", if_rdata, 32'hA0A0_A0A4);

      // Single bank: every simultaneous pair conflicts; two banks: none here.
      for (int i = 0; i < 2; i++) begin
         s_if_req  = 1'b1;
         s_if_addr = 8'h01;
         s_ls_req  = 1'b1;
         s_ls_addr = 8'h02;
         if_req    = 1'b1;
         if_addr   = 14'h0001;
         ls_req    = 1'b1;
         ls_web    = 1'b1;
         ls_addr   = 14'h0002;
         #1;
         check_eq("nb1_one_gnt", 32'(s_if_gnt) + 32'(s_ls_gnt), 32'd1);
         check_eq("nb1_ls_gnt", 32'(s_ls_gnt), 32'(exp_ls039[i]));
         check_eq("nb2_both_gnt", 32'(if_gnt) + 32'(ls_gnt), 32'd2);
         tick();
      end
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arb_banked.md
MEM_ARB_BANKED -- requirements
Module: mem_arb_banked

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of each requestor port.
REQ-002 SHALL have parameter DATA_W, default 32, data width of each word.
REQ-003 SHALL have parameter NUM_BANKS, default 2, number of interleaved single-port banks; power of two, 1..8.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-007 SHALL have port if_addr  input  ADDR_W  instruction-fetch word address.
REQ-008 SHALL have port if_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 SHALL have port if_rvalid  output  1  fetch read data valid.
REQ-010 SHALL have port if_rdata  output  DATA_W  fetch read data.
REQ-011 SHALL have port ls_req  input  1  load/store request.
REQ-012 SHALL have port ls_web  input  1  0 = write, 1 = read.
REQ-013 SHALL have port ls_bweb  input  DATA_W  bit write enable, active low; 0 = bit written.
REQ-014 SHALL have port ls_addr  input  ADDR_W  load/store word address.
REQ-015 SHALL have port ls_wdata  input  DATA_W  store data.
REQ-016 SHALL have port ls_gnt  output  1  load/store request accepted this cycle (combinational).
REQ-017 SHALL have port ls_rvalid  output  1  load data valid.
REQ-018 SHALL have port ls_rdata  output  DATA_W  load data.

Function
REQ-019 SHALL select bank = addr[log2(NUM_BANKS)-1:0] and row = remaining upper bits; with NUM_BANKS=1, all requests target bank 0.
REQ-020 SHALL contain NUM_BANKS internal arrays of 2^ADDR_W/NUM_BANKS words each; contents not reset.
REQ-021 SHALL grant both requestors in the same cycle when they target different banks.
REQ-022 SHALL grant exactly one requestor on a same-bank conflict; the loser sees gnt=0 and must hold req/addr/data stable until granted.
REQ-023 SHALL assert gnt only while the corresponding req is high.
REQ-024 SHALL, for a granted read, drive rvalid high for exactly one cycle on the cycle after grant, with rdata = word at that address as of the grant edge.
REQ-025 SHALL, for a granted write, update bits whose ls_bweb bit is 0 at the grant edge; ls_rvalid is not asserted for writes.
REQ-026 SHALL hold rdata at its last value while rvalid is low.
REQ-027 SHALL make a read granted the cycle after a write to the same address return the new data.
REQ-028 SHALL sustain back-to-back grants every cycle per port with no bubble.

Reset
REQ-029 SHALL, while rst=0, force if_rvalid=0, ls_rvalid=0, if_rdata=0, ls_rdata=0, and the priority pointer to IF-first, regardless of clk.
REQ-030 SHALL drop any read response pending when reset asserts; no rvalid follows reset release.
REQ-031 SHALL, during reset, perform no array writes; gnt outputs are 0.

Configuration
REQ-032 SHALL, with MEM_ARB_RR_EN defined, resolve conflicts round-robin: the winner of each conflict becomes lowest priority for the next conflict; non-conflict grants do not move the pointer.
REQ-033 SHALL, without MEM_ARB_RR_EN, resolve every conflict with fixed priority LS over IF, with no pointer state.

Verification
REQ-034 SHALL cover: NUM_BANKS=2, IF read addr 0x0004 and LS read addr 0x0005 same cycle -> both gnt=1, both rvalid next cycle with stored data.
REQ-035 SHALL cover: LS write addr 0x0010, wdata 0xDEADBEEF, bweb 0xFFFF0000 over prior 0x12345678 -> later read returns 0x1234BEEF.
REQ-036 SHALL cover: IF and LS both addr 0x0008 for 3 cycles, RR defined -> cycle grants IF, LS, IF; RR undefined -> LS, LS, LS with if_gnt=0.
REQ-037 SHALL cover: LS write 0xCAFEF00D to 0x0020, IF read 0x0020 next cycle -> if_rdata=0xCAFEF00D.
REQ-038 SHALL cover: read granted, rst driven low mid-cycle before next edge -> if_rvalid=0, if_rdata=0 immediately, no rvalid after release.
REQ-039 SHALL cover: NUM_BANKS=1, IF 0x0001 and LS 0x0002 simultaneous -> exactly one gnt per cycle.
